// File: rtl/burst_ram_slave.sv
// Purpose: single-port burst RAM slave on a wired-OR bus; all outputs stay 0 unless this slave is selected.
// Latency: the first read word appears 3 cycles after begin; writes land in memory one cycle after each dataValidIn.
// Backpressure: master busyIn rejects the word shown that cycle; the slave then idles one cycle and shows it again (busyOut is tied 0).
// Optional feature: define BURST_RAM_SLAVE_BUSERR_EN to compile in bus-error signalling. Without it, offending accesses are truncated.
module burst_ram_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_BITS    = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic        endTransactionIn,
  input  logic        dataValidIn,
  input  logic        busyIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  // Word index is wider than the memory so that bursts running off the top are detectable.
  localparam int unsigned IW = ADDR_BITS + 10;
  localparam logic [32:0]   SPAN      = 33'(DEPTH) << 2;
  localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    READ_SETUP,
    READ_BURST,
    READ_END,
    WRITE_BURST
`ifdef BURST_RAM_SLAVE_BUSERR_EN
    , ERROR,
    ERROR_END
`endif
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [8:0]    rem_q, rem_d;
  logic [3:0]    be_q, be_d;

  logic [31:0]   offset;
  logic          sel;
  logic [IW-1:0] start_idx;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic          wr_en;
  logic          in_range;

  assign offset    = addressDataIn - BASE_ADDRESS;
  assign sel       = beginTransactionIn && (addressDataIn >= BASE_ADDRESS) && ({1'b0, offset} < SPAN);
  assign start_idx = IW'(offset[ADDR_BITS+1:2]);
  assign in_range  = idx_q < DEPTH_IDX;

`ifdef BURST_RAM_SLAVE_BUSERR_EN
  logic [IW-1:0] last_idx;
  logic          bad_begin;
  assign last_idx  = start_idx + IW'(burstSizeIn);
  assign bad_begin = (|addressDataIn[1:0]) || (last_idx >= DEPTH_IDX);
`endif

  assign busyOut = 1'b0;

  // Next-state, burst bookkeeping and memory read/write strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    be_d    = be_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel) begin
          be_d  = byteEnablesIn;
          idx_d = start_idx;
          rem_d = 9'(burstSizeIn) + 9'd1;
`ifdef BURST_RAM_SLAVE_BUSERR_EN
          if (bad_begin)           state_d = ERROR;
          else if (readNotWriteIn) state_d = READ_SETUP;
          else                     state_d = WRITE_BURST;
`else
          state_d = readNotWriteIn ? READ_SETUP : WRITE_BURST;
`endif
        end
      end
      READ_SETUP: state_d = READ_BURST;
      READ_BURST: begin
        if (dataValidOut && !busyIn) begin
          // Word accepted: advance, and either show the next one or finish.
          idx_d = idx_q + IW'(1);
          rem_d = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = READ_END;
          end else begin
            rd_en  = 1'b1;
            rd_idx = idx_q + IW'(1);
          end
        end else if (!dataValidOut && !busyIn) begin
          // Nothing on the bus (first word, or after a rejected word): show the current word.
          rd_en = 1'b1;
        end
      end
      READ_END: state_d = IDLE;
      WRITE_BURST: begin
        if (dataValidIn) begin
`ifdef BURST_RAM_SLAVE_BUSERR_EN
          if (rem_q == 9'd0) begin
            state_d = ERROR;
          end else begin
            wr_en = 1'b1;
            idx_d = idx_q + IW'(1);
            rem_d = rem_q - 9'd1;
          end
`else
          if (rem_q != 9'd0) begin
            wr_en = in_range;
            idx_d = idx_q + IW'(1);
            rem_d = rem_q - 9'd1;
          end
`endif
        end
        if (endTransactionIn && state_d == WRITE_BURST) state_d = IDLE;
      end
`ifdef BURST_RAM_SLAVE_BUSERR_EN
      ERROR:     state_d = ERROR_END;
      ERROR_END: state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase
  end

  // State and burst registers; reset abandons any burst in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      be_q    <= be_d;
    end
  end

  // Bus outputs, registered from the next state so they are 0 whenever the slave is not driving.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addressDataOut    <= '0;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
    end else begin
      dataValidOut   <= rd_en;
      addressDataOut <= (rd_en && rd_idx < DEPTH_IDX) ? mem[rd_idx[ADDR_BITS-1:0]] : '0;
`ifdef BURST_RAM_SLAVE_BUSERR_EN
      endTransactionOut <= (state_d == READ_END) || (state_d == ERROR_END);
      busErrorOut       <= (state_d == ERROR);
`else
      endTransactionOut <= (state_d == READ_END);
      busErrorOut       <= 1'b0;
`endif
    end
  end

  // Byte-lane memory write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q[ADDR_BITS-1:0]][8*b +: 8] <= addressDataIn[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_burst_ram_slave.sv
// Purpose: scoreboard bench for burst_ram_slave; directed bursts push expected bus events, a monitor checks them.
// Latency: expected events carry the absolute cycle in which they must appear.
// Backpressure: busyIn is raised for single cycles to force a held-and-repeated read word.
module tb_burst_ram_slave;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clock;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic        endTransactionIn;
  logic        dataValidIn;
  logic        busyIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;
  logic        busyOut;

  burst_ram_slave #(.BASE_ADDRESS(BASE), .ADDR_BITS(9)) dut (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
    .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
    .readNotWriteIn(readNotWriteIn), .endTransactionIn(endTransactionIn),
    .dataValidIn(dataValidIn), .busyIn(busyIn),
    .addressDataOut(addressDataOut), .dataValidOut(dataValidOut),
    .endTransactionOut(endTransactionOut), .busErrorOut(busErrorOut),
    .busyOut(busyOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // kind: 0 = accepted read word, 1 = endTransactionOut, 2 = busErrorOut
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          at;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model [512];
  logic [31:0] wdata [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model_rd(input int idx);
    return (idx < 512) ? model[idx] : 32'h0;
  endfunction

  function automatic void push(input int kind, input logic [31:0] d, input int at);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  // Monitor: every bus event pops the scoreboard; idle data must read 0.
  always @(negedge clock) begin
    int   akind;
    int   n;
    ev_t  e;
    if (mon_en) begin
      akind = -1;
      n     = 0;
      if (dataValidOut && !busyIn) begin akind = 0; n++; end
      if (endTransactionOut)       begin akind = 1; n++; end
      if (busErrorOut)             begin akind = 2; n++; end
      if (n > 1) akind = 3;
      if (n > 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got kind %0d data %h at cycle %0d, required no event", akind, addressDataOut, cyc);
        end else begin
          e = exp_q.pop_front();
          if (akind != e.kind || cyc != e.at || (e.kind == 0 && addressDataOut !== e.data)) begin
            fails++;
            $display("FAIL bus_event: got kind %0d data %h cycle %0d, required kind %0d data %h cycle %0d",
                     akind, addressDataOut, cyc, e.kind, e.data, e.at);
          end
        end
      end
      if (!dataValidOut) check("idle_data_zero", addressDataOut, 32'h0);
      check("busy_out_zero", {31'h0, busyOut}, 32'h0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    beginTransactionIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0; burstSizeIn = '0;
    readNotWriteIn = 1'b0; endTransactionIn = 1'b0; dataValidIn = 1'b0; busyIn = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] be, input int burst,
                             input int nwords, input bit selected);
    int c;
    int base_idx;
    step();
    c = cyc;
    beginTransactionIn = 1'b1; addressDataIn = addr; byteEnablesIn = be;
    burstSizeIn = 8'(burst); readNotWriteIn = 1'b0;
    if (selected) begin
      base_idx = int'((addr - BASE) >> 2);
      for (int i = 0; i < nwords; i++) begin
        if (i <= burst && base_idx + i < 512) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) model[base_idx + i][8*b +: 8] = wdata[i][8*b +: 8];
        end
      end
`ifdef BURST_RAM_SLAVE_BUSERR_EN
      if (nwords > burst + 1) begin
        push(2, 32'h0, c + burst + 3);
        push(1, 32'h0, c + burst + 4);
      end
`endif
    end
    for (int i = 0; i < nwords; i++) begin
      step();
      beginTransactionIn = 1'b0;
      dataValidIn = 1'b1; addressDataIn = wdata[i]; endTransactionIn = (i == nwords - 1);
    end
    step();
    quiet();
    repeat (3) step();
  endtask

  // busy_at: index of the read word whose first presentation the master rejects (-1 for none).
  task automatic read_burst(input logic [31:0] addr, input int burst, input int busy_at, input bit selected);
    int c;
    int idx;
    int shift;
    step();
    c = cyc;
    beginTransactionIn = 1'b1; addressDataIn = addr; burstSizeIn = 8'(burst); readNotWriteIn = 1'b1;
    if (selected) begin
      idx   = int'((addr - BASE) >> 2);
      shift = 0;
`ifdef BURST_RAM_SLAVE_BUSERR_EN
      if (idx + burst >= 512) begin
        push(2, 32'h0, c + 1);
        push(1, 32'h0, c + 2);
      end else begin
`else
      begin
`endif
        for (int k = 0; k <= burst; k++) begin
          if (k == busy_at) shift += 2;
          push(0, model_rd(idx + k), c + 3 + k + shift);
        end
        push(1, 32'h0, c + 4 + burst + shift);
      end
    end
    while (cyc < c + burst + 10) begin
      step();
      beginTransactionIn = 1'b0; addressDataIn = '0;
      busyIn = (busy_at >= 0 && cyc == c + 3 + busy_at);
    end
    quiet();
  endtask

  initial begin
    int c;
    for (int i = 0; i < 512; i++) model[i] = 32'h0;
    quiet();
    reset = 1'b0;
    repeat (3) step();
    mon_en = 1'b1;
    @(negedge clock);
    check("reset_data",  addressDataOut, 32'h0);
    check("reset_valid", {31'h0, dataValidOut}, 32'h0);
    check("reset_end",   {31'h0, endTransactionOut}, 32'h0);
    check("reset_err",   {31'h0, busErrorOut}, 32'h0);
    step();
    reset = 1'b1;
    step();

    // mem[4..7] = 1,2,3,4 then a 4-word read: data in cycles 3..6, end in cycle 7.
    wdata[0] = 32'd1; wdata[1] = 32'd2; wdata[2] = 32'd3; wdata[3] = 32'd4;
    write_burst(BASE + 32'h10, 4'hF, 3, 4, 1'b1);
    read_burst(BASE + 32'h10, 3, -1, 1'b1);

    // Byte-lane write over a zeroed word: expect 0000CCDD.
    wdata[0] = 32'h0; wdata[1] = 32'h0BAD_F00D;
    write_burst(BASE, 4'hF, 1, 2, 1'b1);
    wdata[0] = 32'hAABB_CCDD;
    write_burst(BASE, 4'b0011, 0, 1, 1'b1);
    read_burst(BASE, 1, -1, 1'b1);

    // Master busy on the second data cycle: that word is held and repeated.
    read_burst(BASE + 32'h10, 1, 1, 1'b1);
    read_burst(BASE + 32'h14, 2, 0, 1'b1);

    // Burst running past the top of memory.
    wdata[0] = 32'hA5A5_0001; wdata[1] = 32'hA5A5_0002;
    write_burst(BASE + 32'd2040, 4'hF, 1, 2, 1'b1);
    read_burst(BASE + 32'd2040, 3, -1, 1'b1);

    // Write carrying more words than its burst size: the extra word must not land.
    wdata[0] = 32'h0000_0055;
    write_burst(BASE + 32'h24, 4'hF, 0, 1, 1'b1);
    wdata[0] = 32'h0000_0077; wdata[1] = 32'h0000_0088;
    write_burst(BASE + 32'h20, 4'hF, 0, 2, 1'b1);
    read_burst(BASE + 32'h20, 1, -1, 1'b1);

    // Reset during word 2 of an 8-word read.
    for (int i = 0; i < 8; i++) wdata[i] = 32'h1000_0000 + i;
    write_burst(BASE + 32'h40, 4'hF, 7, 8, 1'b1);
    step();
    c = cyc;
    beginTransactionIn = 1'b1; addressDataIn = BASE + 32'h40; burstSizeIn = 8'd7; readNotWriteIn = 1'b1;
    push(0, model[16], c + 3);
    push(0, model[17], c + 4);
    step(); quiet();
    step(); step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    check("midreset_data",  addressDataOut, 32'h0);
    check("midreset_valid", {31'h0, dataValidOut}, 32'h0);
    check("midreset_end",   {31'h0, endTransactionOut}, 32'h0);
    check("midreset_err",   {31'h0, busErrorOut}, 32'h0);
    step();
    read_burst(BASE + 32'h44, 1, -1, 1'b1);

    // Addresses outside the window: nothing driven, memory untouched.
    read_burst(BASE - 32'd4, 1, -1, 1'b0);
    wdata[0] = 32'hDEAD_0000; wdata[1] = 32'hDEAD_0001;
    write_burst(BASE - 32'd4, 4'hF, 1, 2, 1'b0);
    write_burst(BASE + 32'd2048, 4'hF, 1, 2, 1'b0);
    read_burst(BASE + 32'd2048, 0, -1, 1'b0);
    read_burst(BASE, 1, -1, 1'b1);
    read_burst(BASE + 32'd2044, 0, -1, 1'b1);

    repeat (5) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
